regfile_write_queue: RTL and testbench
======================================

# regfile_write_queue

Write-side companion to the CPU register file. It accepts register write-back requests from the execute/memory stages, buffers them in a small FIFO, and drains one per cycle into the register file's write port (`wr_reg`/`wr_data`/`reg_write`), respecting `stall`. It also exposes two forwarding lookup ports so decode can see values that are queued but not yet written.

## Interface
- `DEPTH`, 4, queue entries; power of two, ≥2
- `ADDR_WIDTH`, 5, register address width
- `DATA_WIDTH`, 32, register data width

- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  write-back request present
- `in_ready`  out  1  queue can accept a request
- `in_reg`  in  ADDR_WIDTH  destination register
- `in_data`  in  DATA_WIDTH  value to write
- `stall`  in  1  pipeline stall; inhibits draining
- `wr_reg`  out  ADDR_WIDTH  register file write address
- `wr_data`  out  DATA_WIDTH  register file write data
- `reg_write`  out  1  register file write enable
- `fwd_reg1`, `fwd_reg2`  in  ADDR_WIDTH  lookup addresses
- `fwd_hit1`, `fwd_hit2`  out  1  lookup matched a queued entry
- `fwd_data1`, `fwd_data2`  out  DATA_WIDTH  youngest matching queued value
- `count`  out  $clog2(DEPTH)+1  occupied entries
- `empty`  out  1  count == 0

## Operation
- Circular buffer: head (oldest), tail (next free), and a count register. Pointers wrap modulo DEPTH.
- Accept on `in_valid & in_ready`. `in_ready = (count < DEPTH)` and depends only on registered state, never on a same-cycle pop.
- Writes to register 0 complete the handshake but are discarded (not enqueued, count unchanged).
- Drain: `reg_write = ~empty & ~stall`. `wr_reg`/`wr_data` show the head entry whenever non-empty. When empty, `wr_reg`/`wr_data` = 0. The head pops on the edge where `reg_write` = 1.
- Simultaneous push and pop: count unchanged, both pointers advance. When full, a pop in the same cycle does not raise `in_ready`.
- Forwarding (each port independent, combinational):
  - Compare against all occupied entries, including the head being drained this cycle.
  - The youngest match (closest to tail) wins.
  - `fwd_reg == 0` gives hit = 0 and data = 0. No match gives hit = 0 and data = 0.
  - An entry being enqueued in the current cycle is not visible until the next cycle.
- `stall` freezes draining only; enqueue continues while stalled.

## Timing
- Reset (async, immediate): head = tail = 0, count = 0, and all entry storage is cleared. While reset is high: `reg_write` = 0, `wr_reg`/`wr_data` = 0, `empty` = 1, `count` = 0, `in_ready` = 1, `fwd_hit*` = 0, `fwd_data*` = 0. Handshakes during reset are ignored.
- Reset mid-operation: all queued writes are lost; nothing is emitted after reset deasserts until a new push.
- Latency: a request accepted at edge N drives `reg_write` in cycle N+1 (if there is no stall and the queue was empty). The register file commits it at edge N+1.
- Throughput: one accept and one drain per cycle.
- Ordering: writes reach the register file in acceptance order. A later write to the same register always lands after the earlier one.

## Structure
- Shared package `regfile_pkg` holds:
  - `ADDR_WIDTH`/`DATA_WIDTH` defaults
  - the `ZERO_REG` constant
  - the `wq_entry_t` struct {reg, data}
- Local constant `PTR_WIDTH = $clog2(DEPTH)`.
- One sub-module, `wq_fwd_match`: a youngest-match priority search over the entry array given head and count. It is instantiated once per lookup port.

## Test plan
- **Single write:** after reset, push (r5, 0xDEADBEEF) → the next cycle shows `reg_write` = 1, `wr_reg` = 5, `wr_data` = 0xDEADBEEF; the cycle after that shows `empty` = 1.
- **Fill under stall:** hold `stall` = 1 and push 4 entries → `count` = 4, `in_ready` = 0, `reg_write` = 0. A fifth push is held off. Releasing the stall drains all 4 in order over 4 cycles.
- **Forward youngest:** queue (r3, 0x11) then (r3, 0x22) under stall, set `fwd_reg1` = 3 → `fwd_hit1` = 1, `fwd_data1` = 0x22. Setting `fwd_reg2` = 4 → `fwd_hit2` = 0.
- **Register 0:** push (r0, 0xFFFF) → handshake completes, `count` stays 0, no `reg_write`. `fwd_reg1` = 0 gives hit = 0.
- **Push + pop:** with count = 2 and no stall, push every cycle for 5 cycles → `count` stays 2 and the output order matches the input order.
- **Reset mid-drain:** with 3 entries queued, pulse `reset` between edges → outputs go to 0 immediately, `count` = 0, and no further writes occur after deassertion.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file types and constants.
// Latency: n/a (types only).
// Backpressure: n/a.
package regfile_pkg;

  localparam int ADDR_WIDTH = 5;
  localparam int DATA_WIDTH = 32;

  // Architectural zero register: writes are dropped, lookups never hit.
  localparam int ZERO_REG = 0;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] reg_addr;
    logic [DATA_WIDTH-1:0] data;
  } wq_entry_t;

endpackage

// File: rtl/wq_fwd_match.sv
// Youngest-match search over the occupied write-queue entries.
// Latency: purely combinational.
// Backpressure: none; pure lookup.
module wq_fwd_match
  import regfile_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
  parameter int PTR_WIDTH  = $clog2(DEPTH)
) (
  input  logic [ADDR_WIDTH-1:0] entry_reg  [DEPTH],
  input  logic [DATA_WIDTH-1:0] entry_data [DEPTH],
  input  logic [PTR_WIDTH-1:0]  head,
  input  logic [PTR_WIDTH:0]    count,
  input  logic [ADDR_WIDTH-1:0] lookup,
  output logic                  hit,
  output logic [DATA_WIDTH-1:0] data
);

  logic [PTR_WIDTH-1:0] idx;

  // Walk from oldest to youngest; a later match overwrites an earlier one,
  // so the entry closest to the tail wins.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_WIDTH'(i);
      if (((PTR_WIDTH + 1)'(i) < count) &&
          (lookup != ADDR_WIDTH'(ZERO_REG)) &&
          (entry_reg[idx] == lookup)) begin
        hit  = 1'b1;
        data = entry_data[idx];
      end
    end
  end

endmodule

// File: rtl/regfile_write_queue.sv
// Buffers register write-backs and drains one per cycle into the regfile write port, with forwarding lookups.
// Latency: push at edge N drives reg_write in cycle N+1 when empty and unstalled.
// Backpressure: in_ready = count < DEPTH from registered state; stall holds the head.
module regfile_write_queue
  import regfile_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADDR_WIDTH-1:0]   in_reg,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    stall,
  output logic [ADDR_WIDTH-1:0]   wr_reg,
  output logic [DATA_WIDTH-1:0]   wr_data,
  output logic                    reg_write,
  input  logic [ADDR_WIDTH-1:0]   fwd_reg1,
  input  logic [ADDR_WIDTH-1:0]   fwd_reg2,
  output logic                    fwd_hit1,
  output logic                    fwd_hit2,
  output logic [DATA_WIDTH-1:0]   fwd_data1,
  output logic [DATA_WIDTH-1:0]   fwd_data2,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty
);

  localparam int PTR_WIDTH = $clog2(DEPTH);
  localparam int CNT_WIDTH = PTR_WIDTH + 1;

  logic [ADDR_WIDTH-1:0] entry_reg  [DEPTH];
  logic [DATA_WIDTH-1:0] entry_data [DEPTH];
  logic [PTR_WIDTH-1:0]  head_q;
  logic [PTR_WIDTH-1:0]  tail_q;
  logic [CNT_WIDTH-1:0]  count_q;
  logic                  push;
  logic                  pop;

  // Readiness comes from registered occupancy only, so a same-cycle pop
  // never opens the door when full.
  assign in_ready  = (count_q != CNT_WIDTH'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;

  // Register-0 writes still handshake but never occupy a slot.
  assign push      = in_valid & in_ready & (in_reg != ADDR_WIDTH'(ZERO_REG));
  assign reg_write = ~empty & ~stall;
  assign pop       = reg_write;

  assign wr_reg    = empty ? '0 : entry_reg[head_q];
  assign wr_data   = empty ? '0 : entry_data[head_q];

  // Entry storage: cleared on reset, written at the tail on push.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_reg[i]  <= '0;
        entry_data[i] <= '0;
      end
    end else if (push) begin
      entry_reg[tail_q]  <= in_reg;
      entry_data[tail_q] <= in_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + 1'b1;
      if (pop)  head_q <= head_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  wq_fwd_match #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .PTR_WIDTH  (PTR_WIDTH)
  ) u_fwd1 (
    .entry_reg  (entry_reg),
    .entry_data (entry_data),
    .head       (head_q),
    .count      (count_q),
    .lookup     (fwd_reg1),
    .hit        (fwd_hit1),
    .data       (fwd_data1)
  );

  wq_fwd_match #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .PTR_WIDTH  (PTR_WIDTH)
  ) u_fwd2 (
    .entry_reg  (entry_reg),
    .entry_data (entry_data),
    .head       (head_q),
    .count      (count_q),
    .lookup     (fwd_reg2),
    .hit        (fwd_hit2),
    .data       (fwd_data2)
  );

endmodule

// File: tb/tb_regfile_write_queue.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based reference model.
// Latency: model checked every cycle at the falling edge.
// Backpressure: random stall and full-queue conditions exercised.
module tb_regfile_write_queue;
  import regfile_pkg::*;

  localparam int DEPTH = 4;

  logic                  clk;
  logic                  reset;
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] in_reg;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  stall;
  logic [ADDR_WIDTH-1:0] wr_reg;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  reg_write;
  logic [ADDR_WIDTH-1:0] fwd_reg1;
  logic [ADDR_WIDTH-1:0] fwd_reg2;
  logic                  fwd_hit1;
  logic                  fwd_hit2;
  logic [DATA_WIDTH-1:0] fwd_data1;
  logic [DATA_WIDTH-1:0] fwd_data2;
  logic [2:0]            count;
  logic                  empty;

  int errors = 0;
  int checks = 0;

  // Reference model: the queued writes, oldest first.
  wq_entry_t q[$];

  regfile_write_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_reg    (in_reg),
    .in_data   (in_data),
    .stall     (stall),
    .wr_reg    (wr_reg),
    .wr_data   (wr_data),
    .reg_write (reg_write),
    .fwd_reg1  (fwd_reg1),
    .fwd_reg2  (fwd_reg2),
    .fwd_hit1  (fwd_hit1),
    .fwd_hit2  (fwd_hit2),
    .fwd_data1 (fwd_data1),
    .fwd_data2 (fwd_data2),
    .count     (count),
    .empty     (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_fwd(input logic [ADDR_WIDTH-1:0] r, output logic hit,
                                    output logic [DATA_WIDTH-1:0] d);
    hit = 1'b0;
    d   = '0;
    if (r != 0) begin
      foreach (q[i]) begin
        if (q[i].reg_addr == r) begin
          hit = 1'b1;
          d   = q[i].data;
        end
      end
    end
  endfunction

  task automatic check_model();
    logic                  h1, h2;
    logic [DATA_WIDTH-1:0] d1, d2;
    logic                  nonempty;
    nonempty = (q.size() > 0);
    model_fwd(fwd_reg1, h1, d1);
    model_fwd(fwd_reg2, h2, d2);
    chk("reg_write", reg_write, nonempty && !stall && !reset);
    chk("wr_reg",    wr_reg,    nonempty ? q[0].reg_addr : '0);
    chk("wr_data",   wr_data,   nonempty ? q[0].data : '0);
    chk("count",     count,     q.size());
    chk("empty",     empty,     !nonempty);
    chk("in_ready",  in_ready,  q.size() < DEPTH);
    chk("fwd_hit1",  fwd_hit1,  h1);
    chk("fwd_data1", fwd_data1, d1);
    chk("fwd_hit2",  fwd_hit2,  h2);
    chk("fwd_data2", fwd_data2, d2);
  endtask

  task automatic model_edge();
    bit do_pop;
    bit do_push;
    wq_entry_t e;
    if (reset) return;
    do_pop  = (q.size() > 0) && !stall;
    do_push = in_valid && (q.size() < DEPTH) && (in_reg != 0);
    e.reg_addr = in_reg;
    e.data     = in_data;
    if (do_pop)  void'(q.pop_front());
    if (do_push) q.push_back(e);
  endtask

  // One clock: check at the falling edge, advance the model at the rising
  // edge, return just after it so the caller can change inputs.
  task automatic cycle();
    @(negedge clk);
    check_model();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input bit v, input int r, input logic [DATA_WIDTH-1:0] d);
    in_valid = v;
    in_reg   = ADDR_WIDTH'(r);
    in_data  = d;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_reg = '0; in_data = '0;
    stall = 1'b0; fwd_reg1 = '0; fwd_reg2 = '0;
    cycle();
    cycle();
    reset = 1'b0;
    cycle();

    // Single write
    drive(1, 5, 32'hDEADBEEF);
    cycle();
    drive(0, 0, 0);
    chk("single_we",   reg_write, 1);
    chk("single_reg",  wr_reg,    5);
    chk("single_data", wr_data,   32'hDEADBEEF);
    cycle();
    chk("single_empty", empty, 1);

    // Fill under stall, fifth push held off, then in-order drain
    stall = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1, i, 32'h100 + i);
      cycle();
    end
    chk("fill_count", count,     4);
    chk("fill_ready", in_ready,  0);
    chk("fill_we",    reg_write, 0);
    drive(1, 6, 32'h666);
    cycle();
    chk("fill_hold_count", count, 4);
    drive(0, 0, 0);
    stall = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_reg",  wr_reg,  i);
      chk("drain_data", wr_data, 32'h100 + i);
      cycle();
    end
    chk("drain_empty", empty, 1);

    // Forward youngest
    stall = 1'b1;
    drive(1, 3, 32'h11); cycle();
    drive(1, 3, 32'h22); cycle();
    drive(1, 7, 32'h77);
    fwd_reg1 = 5'd3; fwd_reg2 = 5'd7;
    #1;
    chk("fwd_young_hit",  fwd_hit1,  1);
    chk("fwd_young_data", fwd_data1, 32'h22);
    chk("fwd_same_cycle", fwd_hit2,  0);
    cycle();
    drive(0, 0, 0);
    fwd_reg2 = 5'd4;
    #1;
    chk("fwd_miss_hit",  fwd_hit2,  0);
    chk("fwd_miss_data", fwd_data2, 0);
    stall = 1'b0;
    repeat (4) cycle();

    // Register 0
    drive(1, 0, 32'hFFFF);
    fwd_reg1 = 5'd0;
    #1;
    chk("r0_ready", in_ready, 1);
    cycle();
    drive(0, 0, 0);
    chk("r0_count", count,     0);
    chk("r0_we",    reg_write, 0);
    chk("r0_fwd",   fwd_hit1,  0);

    // Push + pop at count 2
    stall = 1'b1;
    drive(1, 1, 32'hA1); cycle();
    drive(1, 2, 32'hA2); cycle();
    stall = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1, 10 + i, 32'hB0 + i);
      cycle();
      chk("pp_count", count, 2);
    end
    drive(0, 0, 0);
    repeat (3) cycle();

    // Reset mid-drain
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 20 + i, 32'hC0 + i);
      cycle();
    end
    drive(0, 0, 0);
    stall = 1'b0;
    #1;
    chk("pre_rst_we", reg_write, 1);
    #1 reset = 1'b1;
    #1;
    chk("rst_we",    reg_write, 0);
    chk("rst_reg",   wr_reg,    0);
    chk("rst_data",  wr_data,   0);
    chk("rst_count", count,     0);
    chk("rst_empty", empty,     1);
    chk("rst_ready", in_ready,  1);
    q.delete();
    #1 reset = 1'b0;
    repeat (3) cycle();
    chk("post_rst_we", reg_write, 0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom);
      stall    = ($urandom_range(0, 3) == 0);
      fwd_reg1 = ADDR_WIDTH'($urandom_range(0, 7));
      fwd_reg2 = ADDR_WIDTH'($urandom_range(0, 7));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
